// File: rtl/alu_4bit_reg.sv
// alu_4bit_reg: 4-bit registered ALU with zero, carry, overflow and parity flags.
// The arithmetic ops (ADD/SUB/INC/DEC/NEG) share one ripple-carry adder. Each op
// supplies its own adder operands and carry-in. All results and flags are
// registered together, so the latency is one cycle.
module alu_4bit_reg (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic [3:0] Opcode,
   output logic [3:0] Out,
   output logic       Z,
   output logic       C,
   output logic       V,
   output logic       P
);

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_INC  = 4'h2;
   localparam logic [3:0] OP_DEC  = 4'h3;
   localparam logic [3:0] OP_AND  = 4'h4;
   localparam logic [3:0] OP_OR   = 4'h5;
   localparam logic [3:0] OP_XOR  = 4'h6;
   localparam logic [3:0] OP_NOT  = 4'h7;
   localparam logic [3:0] OP_NAND = 4'h8;
   localparam logic [3:0] OP_NOR  = 4'h9;
   localparam logic [3:0] OP_XNOR = 4'hA;
   localparam logic [3:0] OP_SHL  = 4'hB;
   localparam logic [3:0] OP_SHR  = 4'hC;
   localparam logic [3:0] OP_ROL  = 4'hD;
   localparam logic [3:0] OP_ROR  = 4'hE;
   localparam logic [3:0] OP_NEG  = 4'hF;

   logic [3:0] add_a;
   logic [3:0] add_b;
   logic       add_cin;
   logic [4:0] carry;
   logic [3:0] sum;
   logic       add_ovf;

   logic [3:0] out_next;
   logic       c_next;
   logic       v_next;
   logic       z_next;
   logic       p_next;

   logic [3:0] out_reg;
   logic       z_reg;
   logic       c_reg;
   logic       v_reg;
   logic       p_reg;

   // Select the adder operands: subtraction-style ops add the inverted operand plus one
   always_comb begin
      add_a   = A;
      add_b   = B;
      add_cin = 1'b0;
      case (Opcode)
         OP_SUB: begin
            add_b   = ~B;
            add_cin = 1'b1;
         end
         OP_INC: begin
            add_b   = 4'h0;
            add_cin = 1'b1;
         end
         OP_DEC: begin
            add_b   = 4'hF;
         end
         OP_NEG: begin
            add_a   = 4'h0;
            add_b   = ~A;
            add_cin = 1'b1;
         end
         default: begin
            add_a   = A;
            add_b   = B;
            add_cin = 1'b0;
         end
      endcase
   end

   // Ripple-carry chain. Signed overflow is the carry into the MSB XOR the carry out of it.
   assign carry[0] = add_cin;
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_ripple
         assign sum[gi]     = add_a[gi] ^ add_b[gi] ^ carry[gi];
         assign carry[gi+1] = (add_a[gi] & add_b[gi]) | (carry[gi] & (add_a[gi] ^ add_b[gi]));
      end
   endgenerate
   assign add_ovf = carry[4] ^ carry[3];

   // Result and flag selection; logic ops clear C and V, shifts clear V
   always_comb begin
      out_next = 4'h0;
      c_next   = 1'b0;
      v_next   = 1'b0;
      case (Opcode)
         OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_NEG: begin
            out_next = sum;
            c_next   = carry[4];
            v_next   = add_ovf;
         end
         OP_AND:  out_next = A & B;
         OP_OR:   out_next = A | B;
         OP_XOR:  out_next = A ^ B;
         OP_NOT:  out_next = ~A;
         OP_NAND: out_next = ~(A & B);
         OP_NOR:  out_next = ~(A | B);
         OP_XNOR: out_next = ~(A ^ B);
         OP_SHL: begin
            out_next = {A[2:0], 1'b0};
            c_next   = A[3];
         end
         OP_SHR: begin
            out_next = {1'b0, A[3:1]};
            c_next   = A[0];
         end
         OP_ROL: begin
            out_next = {A[2:0], A[3]};
            c_next   = A[3];
         end
         OP_ROR: begin
            out_next = {A[0], A[3:1]};
            c_next   = A[0];
         end
         default: begin
            out_next = 4'h0;
            c_next   = 1'b0;
            v_next   = 1'b0;
         end
      endcase
   end

   assign z_next = (out_next == 4'h0);
   assign p_next = ^out_next;

   // Register result and flags together; asynchronous clear on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_reg <= 4'h0;
         z_reg   <= 1'b0;
         c_reg   <= 1'b0;
         v_reg   <= 1'b0;
         p_reg   <= 1'b0;
      end else begin
         out_reg <= out_next;
         z_reg   <= z_next;
         c_reg   <= c_next;
         v_reg   <= v_next;
         p_reg   <= p_next;
      end
   end

   assign Out = out_reg;
   assign Z   = z_reg;
   assign C   = c_reg;
   assign V   = v_reg;
   assign P   = p_reg;

endmodule

// File: tb/tb_alu_4bit_reg.sv
// tb_alu_4bit_reg: scoreboard bench for alu_4bit_reg. The stimulus thread pushes
// expected {Out,Z,C,V,P} into a queue. The monitor pops one entry and compares it
// after every clock edge that sampled an issued op.
module tb_alu_4bit_reg;

   logic       clk;
   logic       rst_n;
   logic [3:0] A;
   logic [3:0] B;
   logic [3:0] Opcode;
   logic [3:0] Out;
   logic       Z;
   logic       C;
   logic       V;
   logic       P;

   logic       issue_valid;
   logic [7:0] exp_q[$];
   int         checks;
   int         passed;

   alu_4bit_reg dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .A      (A),
      .B      (B),
      .Opcode (Opcode),
      .Out    (Out),
      .Z      (Z),
      .C      (C),
      .V      (V),
      .P      (P)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: plain integer arithmetic on unsigned and signed values
   function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
      int ua, ub, sa, sb, r, sr;
      logic [3:0] o;
      logic c, v;
      ua = int'(a);
      ub = int'(b);
      sa = (ua >= 8) ? ua - 16 : ua;
      sb = (ub >= 8) ? ub - 16 : ub;
      c = 1'b0;
      v = 1'b0;
      r = 0;
      sr = 0;
      case (op)
         4'h0: begin r = ua + ub; sr = sa + sb; c = (r > 15); end
         4'h1: begin r = ua - ub + 16; sr = sa - sb; c = (ua >= ub); end
         4'h2: begin r = ua + 1; sr = sa + 1; c = (ua == 15); end
         4'h3: begin r = ua + 15; sr = sa - 1; c = (ua != 0); end
         4'h4: r = int'(a & b);
         4'h5: r = int'(a | b);
         4'h6: r = int'(a ^ b);
         4'h7: r = 15 - ua;
         4'h8: r = 15 - int'(a & b);
         4'h9: r = 15 - int'(a | b);
         4'hA: r = 15 - int'(a ^ b);
         4'hB: begin r = ua * 2; c = (ua >= 8); end
         4'hC: begin r = ua / 2; c = (ua % 2 == 1); end
         4'hD: begin r = ua * 2 + ua / 8; c = (ua >= 8); end
         4'hE: begin r = ua / 2 + (ua % 2) * 8; c = (ua % 2 == 1); end
         default: begin r = 16 - ua; sr = -sa; c = (ua == 0); end
      endcase
      if (op <= 4'h3 || op == 4'hF) v = (sr > 7) || (sr < -8);
      o = 4'(r % 16);
      return {o, (o == 4'h0), c, v, ($countones(o) % 2 == 1)};
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got {Out,Z,C,V,P}=%b_%b required %b_%b",
                    name, act[7:4], act[3:0], exp[7:4], exp[3:0]);
   endtask

   task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                        input logic [7:0] exp);
      @(negedge clk);
      A = a;
      B = b;
      Opcode = op;
      issue_valid = 1'b1;
      exp_q.push_back(exp);
      $display("issue A=%h B=%h op=%h exp=%b", a, b, op, exp);
   endtask

   task automatic idle();
      @(negedge clk);
      issue_valid = 1'b0;
   endtask

   // Monitor: an op sampled with reset high yields its result just after that edge
   always begin
      logic took;
      logic [7:0] e;
      @(posedge clk);
      took = issue_valid && rst_n;
      #1;
      if (took) begin
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL scoreboard: output with no expected entry, got %b", {Out, Z, C, V, P});
         end else begin
            e = exp_q.pop_front();
            chk("result", {Out, Z, C, V, P}, e);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got running required finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] ra, rb, rop;
      checks = 0;
      passed = 0;
      rst_n = 1'b1;
      issue_valid = 1'b0;
      A = 4'h0;
      B = 4'h0;
      Opcode = 4'h0;

      // Load a nonzero result, then reset between edges and check that it clears immediately
      issue(4'h0, 4'h0, 4'h7, {4'hF, 1'b0, 1'b0, 1'b0, 1'b0});
      idle();
      #1 rst_n = 1'b0;
      #1 chk("reset_immediate", {Out, Z, C, V, P}, 8'h00);
      A = 4'h3;
      Opcode = 4'h7;
      @(posedge clk);
      #1 chk("reset_hold1", {Out, Z, C, V, P}, 8'h00);
      @(posedge clk);
      #1 chk("reset_hold2", {Out, Z, C, V, P}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed sweep A=0101 B=1100
      for (int op = 0; op < 16; op++)
         issue(4'b0101, 4'b1100, 4'(op), model(4'b0101, 4'b1100, 4'(op)));

      // Spec boundary cases with literal expectations {Out,Z,C,V,P}
      issue(4'b0101, 4'b1100, 4'h0, {4'b0001, 1'b0, 1'b1, 1'b0, 1'b1});
      issue(4'b0101, 4'b1100, 4'h1, {4'b1001, 1'b0, 1'b0, 1'b1, 1'b0});
      issue(4'b0101, 4'b1100, 4'hF, {4'b1011, 1'b0, 1'b0, 1'b0, 1'b1});
      issue(4'b1111, 4'h0, 4'h2, {4'b0000, 1'b1, 1'b1, 1'b0, 1'b0});
      issue(4'b0111, 4'h0, 4'h2, {4'b1000, 1'b0, 1'b0, 1'b1, 1'b1});
      issue(4'b0000, 4'h0, 4'h3, {4'b1111, 1'b0, 1'b0, 1'b0, 1'b0});
      issue(4'b1000, 4'h0, 4'hF, {4'b1000, 1'b0, 1'b0, 1'b1, 1'b1});
      issue(4'b0111, 4'b0001, 4'h0, {4'b1000, 1'b0, 1'b0, 1'b1, 1'b1});
      issue(4'b0000, 4'b0000, 4'h0, {4'b0000, 1'b1, 1'b0, 1'b0, 1'b0});
      issue(4'b0101, 4'b1100, 4'hE, {4'b1010, 1'b0, 1'b1, 1'b0, 1'b0});

      // Random back-to-back ops, one per cycle
      for (int i = 0; i < 200; i++) begin
         ra = 4'($urandom_range(0, 15));
         rb = 4'($urandom_range(0, 15));
         rop = 4'($urandom_range(0, 15));
         issue(ra, rb, rop, model(ra, rb, rop));
      end

      // Reset in the middle of a sweep, then resume with new inputs
      for (int op = 0; op < 8; op++) begin
         ra = 4'($urandom_range(0, 15));
         rb = 4'($urandom_range(0, 15));
         issue(ra, rb, 4'(op), model(ra, rb, 4'(op)));
      end
      idle();
      #1 rst_n = 1'b0;
      #1 chk("midstream_reset", {Out, Z, C, V, P}, 8'h00);
      @(posedge clk);
      #1 chk("midstream_hold", {Out, Z, C, V, P}, 8'h00);
      #1 rst_n = 1'b1;
      for (int op = 8; op < 16; op++) begin
         ra = 4'($urandom_range(0, 15));
         rb = 4'($urandom_range(0, 15));
         issue(ra, rb, 4'(op), model(ra, rb, 4'(op)));
      end
      idle();
      @(negedge clk);
      @(negedge clk);

      checks++;
      if (exp_q.size() == 0) passed++;
      else $display("FAIL drain: got %0d pending results required 0", exp_q.size());

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
